// File: rtl/imem_boot_pkg.sv
// Shared types and default widths for the instruction-memory boot loader.
package imem_boot_pkg;

  localparam int unsigned ISA_WIDTH       = 16;
  localparam int unsigned IMEM_ADDR_WIDTH = 5;
  localparam int unsigned IMEM_DEPTH      = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/imem_boot_loader_hold_counter.sv
// Loadable down-counter for the core reset hold window.
// expire_o pulses for the one enabled cycle in which the count sits at 1.
module boot_hold_counter #(
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             expire_o
);

  logic [Width-1:0] count_q, count_d;

  // Load takes priority; otherwise count down while enabled and stop at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = en_i && (count_q == Width'(1));

endmodule

// File: rtl/imem_boot_loader.sv
// Boot sequencer: streams instruction words into the instruction memory over a
// valid/ready handshake, holds the core in reset during the load and a short
// hold window, then releases it.
// Optional build macro LOADER_CHKSUM_EN adds Load_chk_i and a modulo-2**ISA_WIDTH
// sum check of the loaded image before the core is released.
module imem_boot_loader #(
  parameter int unsigned ISA_WIDTH       = imem_boot_pkg::ISA_WIDTH,
  parameter int unsigned IMEM_ADDR_WIDTH = imem_boot_pkg::IMEM_ADDR_WIDTH,
  parameter int unsigned IMEM_DEPTH      = imem_boot_pkg::IMEM_DEPTH,
  parameter int unsigned RST_HOLD_CYCLES = 4
) (
  input  logic                       Clk_i,
  input  logic                       Rst_n_i,
  input  logic                       Load_start_i,
  input  logic [IMEM_ADDR_WIDTH:0]   Load_len_i,
  input  logic [ISA_WIDTH-1:0]       Load_data_i,
`ifdef LOADER_CHKSUM_EN
  input  logic [ISA_WIDTH-1:0]       Load_chk_i,
`endif
  input  logic                       Load_valid_i,
  output logic                       Load_ready_o,
  output logic                       Inst_wen_o,
  output logic [IMEM_ADDR_WIDTH-1:0] Inst_addr_o,
  output logic [ISA_WIDTH-1:0]       Input_inst_o,
  output logic                       Cpu_rst_n_o,
  output logic                       Busy_o,
  output logic                       Done_o,
  output logic                       Err_o
);

  import imem_boot_pkg::*;

  localparam int unsigned HoldW = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [IMEM_ADDR_WIDTH:0] DepthLen = (IMEM_ADDR_WIDTH + 1)'(IMEM_DEPTH);

  loader_state_e              state_q;
  logic [IMEM_ADDR_WIDTH-1:0] beat_cnt_q;
  logic [IMEM_ADDR_WIDTH:0]   len_q;
  logic                       err_q;
  logic                       cpu_rst_n_q;
  logic                       done_q;

  logic                       wen_q;
  logic [IMEM_ADDR_WIDTH-1:0] addr_q;
  logic [ISA_WIDTH-1:0]       data_q;

  logic                       len_ok;
  logic                       beat;
  logic                       last_beat;
  logic [IMEM_ADDR_WIDTH:0]   len_last;
  logic                       chk_ok;
  logic                       hold_load;
  logic                       hold_expire;

`ifdef LOADER_CHKSUM_EN
  logic [ISA_WIDTH-1:0]       chk_q;
  logic [ISA_WIDTH-1:0]       sum_q;
  logic [ISA_WIDTH-1:0]       sum_d;

  // Running sum including the word on the handshake this cycle.
  assign sum_d  = sum_q + Load_data_i;
  assign chk_ok = (sum_d == chk_q);
`else
  assign chk_ok = 1'b1;
`endif

  assign len_ok    = (Load_len_i != '0) && (Load_len_i <= DepthLen);
  assign beat      = Load_valid_i && Load_ready_o;
  assign len_last  = len_q - (IMEM_ADDR_WIDTH + 1)'(1);
  assign last_beat = ({1'b0, beat_cnt_q} == len_last);
  assign hold_load = beat && last_beat && chk_ok;

  boot_hold_counter #(
    .Width (HoldW)
  ) u_hold_counter (
    .clk_i      (Clk_i),
    .rst_ni     (Rst_n_i),
    .load_i     (hold_load),
    .load_val_i (HoldW'(RST_HOLD_CYCLES)),
    .en_i       (state_q == HOLD),
    .expire_o   (hold_expire)
  );

  // Sequencer FSM with registered core reset, done and error flags.
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef LOADER_CHKSUM_EN
      chk_q       <= '0;
      sum_q       <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE, RUN: begin
          if (Load_start_i) begin
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            if (len_ok) begin
              state_q    <= LOAD;
              beat_cnt_q <= '0;
              len_q      <= Load_len_i;
              err_q      <= 1'b0;
`ifdef LOADER_CHKSUM_EN
              chk_q      <= Load_chk_i;
              sum_q      <= '0;
`endif
            end else begin
              state_q <= IDLE;
              err_q   <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (beat) begin
            beat_cnt_q <= beat_cnt_q + IMEM_ADDR_WIDTH'(1);
`ifdef LOADER_CHKSUM_EN
            sum_q      <= sum_d;
`endif
            if (last_beat) begin
              if (chk_ok) begin
                state_q <= HOLD;
              end else begin
                state_q <= IDLE;
                err_q   <= 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (hold_expire) begin
            state_q     <= RUN;
            cpu_rst_n_q <= 1'b1;
            done_q      <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write port register: one-cycle write pulse per beat; address and data hold when idle.
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wen_q <= beat;
      if (beat) begin
        addr_q <= beat_cnt_q;
        data_q <= Load_data_i;
      end
    end
  end

  assign Load_ready_o = (state_q == LOAD);
  assign Busy_o       = (state_q == LOAD) || (state_q == HOLD);
  assign Done_o       = done_q;
  assign Err_o        = err_q;
  assign Cpu_rst_n_o  = cpu_rst_n_q;
  assign Inst_wen_o   = wen_q;
  assign Inst_addr_o  = addr_q;
  assign Input_inst_o = data_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader (default parameters).
module tb_imem_boot_loader;

  localparam int unsigned IW = 16;
  localparam int unsigned AW = 5;

  logic          Clk_i = 1'b0;
  logic          Rst_n_i;
  logic          Load_start_i;
  logic [AW:0]   Load_len_i;
  logic [IW-1:0] Load_data_i;
`ifdef LOADER_CHKSUM_EN
  logic [IW-1:0] Load_chk_i;
`endif
  logic          Load_valid_i;
  logic          Load_ready_o;
  logic          Inst_wen_o;
  logic [AW-1:0] Inst_addr_o;
  logic [IW-1:0] Input_inst_o;
  logic          Cpu_rst_n_o;
  logic          Busy_o;
  logic          Done_o;
  logic          Err_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [AW-1:0] wr_addr[$];
  logic [IW-1:0] wr_data[$];

  imem_boot_loader dut (
    .Clk_i        (Clk_i),
    .Rst_n_i      (Rst_n_i),
    .Load_start_i (Load_start_i),
    .Load_len_i   (Load_len_i),
    .Load_data_i  (Load_data_i),
`ifdef LOADER_CHKSUM_EN
    .Load_chk_i   (Load_chk_i),
`endif
    .Load_valid_i (Load_valid_i),
    .Load_ready_o (Load_ready_o),
    .Inst_wen_o   (Inst_wen_o),
    .Inst_addr_o  (Inst_addr_o),
    .Input_inst_o (Input_inst_o),
    .Cpu_rst_n_o  (Cpu_rst_n_o),
    .Busy_o       (Busy_o),
    .Done_o       (Done_o),
    .Err_o        (Err_o)
  );

  always #5 Clk_i = ~Clk_i;

  // Record every memory write, sampled mid-cycle.
  always @(negedge Clk_i) begin
    if (Inst_wen_o === 1'b1) begin
      wr_addr.push_back(Inst_addr_o);
      wr_data.push_back(Input_inst_o);
    end
  end

  task automatic tick();
    @(posedge Clk_i);
    #1;
  endtask

  task automatic test_reset();
    Rst_n_i      = 1'b0;
    Load_start_i = 1'b0;
    Load_len_i   = '0;
    Load_data_i  = '0;
    Load_valid_i = 1'b0;
`ifdef LOADER_CHKSUM_EN
    Load_chk_i   = '0;
`endif
    #12;
    vectors++;
    if ({Load_ready_o, Inst_wen_o, Inst_addr_o, Input_inst_o, Cpu_rst_n_o, Busy_o, Done_o, Err_o}
        !== 27'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b wen=%b addr=%0d data=%h rst_n=%b busy=%b done=%b err=%b, required all 0",
               Load_ready_o, Inst_wen_o, Inst_addr_o, Input_inst_o, Cpu_rst_n_o, Busy_o, Done_o, Err_o);
    end
    tick();
    Rst_n_i = 1'b1;
    tick();
    tick();
    vectors++;
    if (Busy_o !== 1'b0 || Cpu_rst_n_o !== 1'b0 || Done_o !== 1'b0 || Load_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got busy=%b rst_n=%b done=%b rdy=%b, required 0 0 0 0",
               Busy_o, Cpu_rst_n_o, Done_o, Load_ready_o);
    end
  endtask

  task automatic test_basic_load();
    wr_addr.delete();
    wr_data.delete();
    Load_start_i = 1'b1;
    Load_len_i   = 6'd5;
    tick();
    Load_start_i = 1'b0;
    vectors++;
    if (Load_ready_o !== 1'b1 || Busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_enter_load: got rdy=%b busy=%b, required 1 1", Load_ready_o, Busy_o);
    end
    Load_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      Load_data_i = IW'(16'h1001 + i);
      tick();
      vectors++;
      if (Inst_wen_o !== 1'b1 || Inst_addr_o !== AW'(i) || Input_inst_o !== IW'(16'h1001 + i)) begin
        miscompares++;
        $display("FAIL basic_write%0d: got wen=%b addr=%0d data=%h, required wen=1 addr=%0d data=%h",
                 i, Inst_wen_o, Inst_addr_o, Input_inst_o, i, IW'(16'h1001 + i));
      end
    end
    Load_valid_i = 1'b0;
    vectors++;
    if (Load_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_ready_drop: got rdy=%b, required 0", Load_ready_o);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      vectors++;
      if (Cpu_rst_n_o !== (k == 4)) begin
        miscompares++;
        $display("FAIL basic_hold%0d: got rst_n=%b, required %b", k, Cpu_rst_n_o, (k == 4));
      end
    end
    vectors++;
    if (Done_o !== 1'b1 || Busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_run: got done=%b busy=%b, required 1 0", Done_o, Busy_o);
    end
    tick();
    vectors++;
    if (Inst_wen_o !== 1'b0 || Inst_addr_o !== 5'd4 || Input_inst_o !== 16'h1005) begin
      miscompares++;
      $display("FAIL basic_hold_last: got wen=%b addr=%0d data=%h, required 0 4 1005",
               Inst_wen_o, Inst_addr_o, Input_inst_o);
    end
  endtask

  task automatic test_gapped_valid();
    logic [5:0] pat;
    int sent;
    logic bad;
    pat  = 6'b101001;
    sent = 0;
    wr_addr.delete();
    wr_data.delete();
    Load_start_i = 1'b1;
    Load_len_i   = 6'd3;
    tick();
    Load_start_i = 1'b0;
    vectors++;
    if (Cpu_rst_n_o !== 1'b0 || Done_o !== 1'b0 || Busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL gap_reload_start: got rst_n=%b done=%b busy=%b, required 0 0 1",
               Cpu_rst_n_o, Done_o, Busy_o);
    end
    for (int k = 0; k < 6; k++) begin
      Load_valid_i = pat[k];
      Load_data_i  = IW'(16'h2000 + sent * 16'h0011);
      tick();
      if (pat[k]) sent++;
      vectors++;
      if (Busy_o !== 1'b1) begin
        miscompares++;
        $display("FAIL gap_busy%0d: got busy=%b, required 1", k, Busy_o);
      end
    end
    Load_valid_i = 1'b0;
    for (int k = 0; k < 12 && Done_o !== 1'b1; k++) tick();
    vectors++;
    if (Done_o !== 1'b1) begin
      miscompares++;
      $display("FAIL gap_done_timeout: got done=%b, required 1", Done_o);
    end
    bad = (wr_addr.size() != 3);
    if (!bad) begin
      for (int j = 0; j < 3; j++)
        if (wr_addr[j] !== AW'(j) || wr_data[j] !== IW'(16'h2000 + j * 16'h0011)) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL gap_writes: got %0d writes, required 3 writes addr 0..2 data 2000/2011/2022",
               wr_addr.size());
    end
  endtask

  task automatic test_bad_length();
    wr_addr.delete();
    wr_data.delete();
    Load_start_i = 1'b1;
    Load_len_i   = 6'd0;
    tick();
    Load_start_i = 1'b0;
    vectors++;
    if (Err_o !== 1'b1 || Busy_o !== 1'b0 || Done_o !== 1'b0 || Cpu_rst_n_o !== 1'b0
        || Load_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL badlen0: got err=%b busy=%b done=%b rst_n=%b rdy=%b, required 1 0 0 0 0",
               Err_o, Busy_o, Done_o, Cpu_rst_n_o, Load_ready_o);
    end
    tick();
    Load_start_i = 1'b1;
    Load_len_i   = 6'd33;
    tick();
    Load_start_i = 1'b0;
    tick();
    vectors++;
    if (Err_o !== 1'b1 || Busy_o !== 1'b0 || Cpu_rst_n_o !== 1'b0 || Load_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL badlen33: got err=%b busy=%b rst_n=%b rdy=%b, required 1 0 0 0",
               Err_o, Busy_o, Cpu_rst_n_o, Load_ready_o);
    end
    vectors++;
    if (wr_addr.size() != 0) begin
      miscompares++;
      $display("FAIL badlen_no_write: got %0d writes, required 0", wr_addr.size());
    end
    Load_start_i = 1'b1;
    Load_len_i   = 6'd1;
    tick();
    Load_start_i = 1'b0;
    vectors++;
    if (Err_o !== 1'b0 || Load_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL badlen_clear: got err=%b rdy=%b, required 0 1", Err_o, Load_ready_o);
    end
    Load_valid_i = 1'b1;
    Load_data_i  = 16'h4444;
    tick();
    Load_valid_i = 1'b0;
    for (int k = 0; k < 12 && Done_o !== 1'b1; k++) tick();
    vectors++;
    if (Done_o !== 1'b1 || wr_addr.size() != 1 || Cpu_rst_n_o !== 1'b1) begin
      miscompares++;
      $display("FAIL badlen_len1: got done=%b writes=%0d rst_n=%b, required 1 1 1",
               Done_o, wr_addr.size(), Cpu_rst_n_o);
    end
  endtask

  task automatic test_full_depth();
    logic bad;
    wr_addr.delete();
    wr_data.delete();
    Load_start_i = 1'b1;
    Load_len_i   = 6'd32;
    tick();
    Load_valid_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      // Stray start requests mid-load must be ignored.
      Load_start_i = (i == 10 || i == 20);
      Load_len_i   = (i == 10 || i == 20) ? 6'd2 : 6'd32;
      Load_data_i  = IW'(16'h3000 + i);
      tick();
    end
    Load_start_i = 1'b0;
    Load_valid_i = 1'b0;
    vectors++;
    if (Load_ready_o !== 1'b0 || Inst_wen_o !== 1'b1 || Inst_addr_o !== 5'd31
        || Input_inst_o !== 16'h301f) begin
      miscompares++;
      $display("FAIL full_last: got rdy=%b wen=%b addr=%0d data=%h, required 0 1 31 301f",
               Load_ready_o, Inst_wen_o, Inst_addr_o, Input_inst_o);
    end
    for (int k = 0; k < 12 && Done_o !== 1'b1; k++) tick();
    bad = (wr_addr.size() != 32);
    if (!bad) begin
      for (int j = 0; j < 32; j++)
        if (wr_addr[j] !== AW'(j) || wr_data[j] !== IW'(16'h3000 + j)) bad = 1'b1;
    end
    vectors++;
    if (bad || Done_o !== 1'b1 || Err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL full_image: got writes=%0d done=%b err=%b, required 32 in-order writes done=1 err=0",
               wr_addr.size(), Done_o, Err_o);
    end
  endtask

  task automatic test_reload_reset();
    wr_addr.delete();
    wr_data.delete();
    Load_start_i = 1'b1;
    Load_len_i   = 6'd2;
    tick();
    Load_start_i = 1'b0;
    vectors++;
    if (Cpu_rst_n_o !== 1'b0 || Done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reload_fall: got rst_n=%b done=%b, required 0 0", Cpu_rst_n_o, Done_o);
    end
    Load_valid_i = 1'b1;
    Load_data_i  = 16'h5001;
    tick();
    Load_data_i  = 16'h5002;
    tick();
    Load_valid_i = 1'b0;
    for (int k = 0; k < 12 && Done_o !== 1'b1; k++) tick();
    vectors++;
    if (Done_o !== 1'b1 || Cpu_rst_n_o !== 1'b1 || wr_addr.size() != 2) begin
      miscompares++;
      $display("FAIL reload_done: got done=%b rst_n=%b writes=%0d, required 1 1 2",
               Done_o, Cpu_rst_n_o, wr_addr.size());
    end
    else begin
      vectors++;
      if (wr_addr[1] !== 5'd1 || wr_data[1] !== 16'h5002) begin
        miscompares++;
        $display("FAIL reload_data: got addr=%0d data=%h, required 1 5002", wr_addr[1], wr_data[1]);
      end
    end
    Load_start_i = 1'b1;
    Load_len_i   = 6'd4;
    tick();
    Load_start_i = 1'b0;
    Load_valid_i = 1'b1;
    Load_data_i  = 16'h6000;
    tick();
    #2;
    Rst_n_i = 1'b0;
    #1;
    vectors++;
    if ({Load_ready_o, Inst_wen_o, Inst_addr_o, Input_inst_o, Cpu_rst_n_o, Busy_o, Done_o, Err_o}
        !== 27'd0) begin
      miscompares++;
      $display("FAIL async_reset: got rdy=%b wen=%b addr=%0d data=%h rst_n=%b busy=%b done=%b err=%b, required all 0",
               Load_ready_o, Inst_wen_o, Inst_addr_o, Input_inst_o, Cpu_rst_n_o, Busy_o, Done_o, Err_o);
    end
    tick();
    Rst_n_i      = 1'b1;
    Load_valid_i = 1'b0;
    tick();
    vectors++;
    if (Busy_o !== 1'b0 || Cpu_rst_n_o !== 1'b0 || Load_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got busy=%b rst_n=%b rdy=%b, required 0 0 0",
               Busy_o, Cpu_rst_n_o, Load_ready_o);
    end
  endtask

`ifdef LOADER_CHKSUM_EN
  task automatic test_chksum();
    Load_start_i = 1'b1;
    Load_len_i   = 6'd2;
    Load_chk_i   = 16'h0002;
    tick();
    Load_start_i = 1'b0;
    Load_valid_i = 1'b1;
    Load_data_i  = 16'h0003;
    tick();
    Load_data_i  = 16'hffff;
    tick();
    Load_valid_i = 1'b0;
    for (int k = 0; k < 12 && Done_o !== 1'b1; k++) tick();
    vectors++;
    if (Done_o !== 1'b1 || Err_o !== 1'b0 || Cpu_rst_n_o !== 1'b1) begin
      miscompares++;
      $display("FAIL chk_match: got done=%b err=%b rst_n=%b, required 1 0 1", Done_o, Err_o, Cpu_rst_n_o);
    end
    Load_start_i = 1'b1;
    Load_chk_i   = 16'h0003;
    tick();
    Load_start_i = 1'b0;
    Load_valid_i = 1'b1;
    Load_data_i  = 16'h0003;
    tick();
    Load_data_i  = 16'hffff;
    tick();
    Load_valid_i = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    vectors++;
    if (Err_o !== 1'b1 || Busy_o !== 1'b0 || Done_o !== 1'b0 || Cpu_rst_n_o !== 1'b0) begin
      miscompares++;
      $display("FAIL chk_mismatch: got err=%b busy=%b done=%b rst_n=%b, required 1 0 0 0",
               Err_o, Busy_o, Done_o, Cpu_rst_n_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_gapped_valid();
    test_bad_length();
    test_full_depth();
    test_reload_reset();
`ifdef LOADER_CHKSUM_EN
    test_chksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot sequencer for risc_minimalist.
- Accepts a stream of instruction words over a valid/ready handshake and writes them sequentially into the instruction memory via the core's Inst_wen_i/Input_inst_i path.
- Holds the CPU in reset during the load and for a programmable hold window, then releases it.
- Sits between the external load source (bench or host interface) and the core top level.

Parameters:
- ISA_WIDTH, 16, instruction word width.
- IMEM_ADDR_WIDTH, 5, instruction memory address width.
- IMEM_DEPTH, 32, instruction memory depth in words; must be <= 2**IMEM_ADDR_WIDTH.
- RST_HOLD_CYCLES, 4, cycles Cpu_rst_n_o stays low after the last write; must be >= 1.

Ports:
- Clk_i  input  1  system clock.
- Rst_n_i  input  1  asynchronous active-low reset.
- Load_start_i  input  1  single-cycle start request.
- Load_len_i  input  IMEM_ADDR_WIDTH+1  word count; sampled on an accepted start.
- Load_data_i  input  ISA_WIDTH  instruction word.
- Load_valid_i  input  1  Load_data_i valid.
- Load_ready_o  output  1  loader accepts a word this cycle.
- Inst_wen_o  output  1  instruction memory write enable.
- Inst_addr_o  output  IMEM_ADDR_WIDTH  instruction memory write address.
- Input_inst_o  output  ISA_WIDTH  instruction memory write data.
- Cpu_rst_n_o  output  1  active-low reset to the core.
- Busy_o  output  1  state is LOAD or HOLD.
- Done_o  output  1  state is RUN.
- Err_o  output  1  sticky error flag.

Behaviour:
- Clock and reset: one clock, Clk_i. Rst_n_i is asynchronous, active-low.
- Reset values: all outputs 0. Cpu_rst_n_o=0 (core held in reset). State=IDLE, counters=0.
- States:
  - IDLE: wait for Load_start_i.
  - LOAD: accept words.
  - HOLD: count down the reset hold window.
  - RUN: core running.
- Start acceptance: Load_start_i is accepted in IDLE or RUN.
  - Load_len_i in 1..IMEM_DEPTH: go to LOAD; word counter=0; Err_o cleared.
  - Load_len_i = 0 or > IMEM_DEPTH: go to IDLE; Err_o=1 next cycle; Cpu_rst_n_o=0.
  - Load_start_i in LOAD or HOLD is ignored.
- Cpu_rst_n_o is registered. It falls the cycle after a start accepted in RUN.
- LOAD handshake:
  - Load_ready_o=1 combinationally whenever state==LOAD.
  - A beat transfers when Load_valid_i & Load_ready_o.
  - Valid may be deasserted arbitrarily between beats; no data is lost.
- Write latency: 1 cycle. The cycle after a beat, Inst_wen_o=1 for exactly one cycle, with Inst_addr_o = beat index and Input_inst_o = beat data. Back-to-back beats give back-to-back writes.
- Addressing: indices run 0..len-1. No wrap-around is possible because len is range-checked.
- Outputs when idle: Inst_addr_o and Input_inst_o hold their last value when Inst_wen_o=0.
- Last beat (index len-1): go to HOLD; Load_ready_o=0 from the next cycle. The hold counter loads RST_HOLD_CYCLES.
- HOLD:
  - Counter decrements each cycle.
  - When it reaches 1, go to RUN.
  - Cpu_rst_n_o=1 and Done_o=1 are registered on RUN entry.
  - The final write completes before the hold window elapses.
- RUN: stays until Load_start_i (reload) or reset.
- Reset mid-operation: everything returns to reset values immediately. A partial image is left in memory. The core stays in reset until a full load completes.

Optional Feature:
- Macro: LOADER_CHKSUM_EN.
- When defined:
  - Extra input Load_chk_i [ISA_WIDTH-1:0], sampled with the start request.
  - The loader accumulates a modulo-2**ISA_WIDTH sum of all accepted words.
  - On the last beat, the sum including that word is compared with Load_chk_i.
  - Match: normal HOLD/RUN.
  - Mismatch: go to IDLE; Err_o=1; Cpu_rst_n_o stays 0.
- When undefined: no port, no adder, and the load always proceeds to HOLD.

Decomposition:
- Package imem_boot_pkg:
  - State enum loader_state_e {IDLE, LOAD, HOLD, RUN}.
  - Default width constants ISA_WIDTH=16, IMEM_ADDR_WIDTH=5, IMEM_DEPTH=32.
- One natural sub-module: boot_hold_counter, a loadable down-counter producing an expiry pulse.
- FSM, beat counter and write register stay in the top module.

Test Plan:
- Basic load: start with len=5, words 0x1001..0x1005, valid held high.
  - Inst_wen_o pulses on 5 consecutive cycles at addr 0..4.
  - Cpu_rst_n_o rises 4 cycles after the last write; Done_o=1.
- Gapped valid: len=3, valid toggled 1,0,0,1,0,1.
  - Exactly 3 writes at addr 0,1,2 with the correct data.
  - Busy_o high throughout LOAD and HOLD.
- Bad length: len=0, then len=33.
  - Err_o=1, state stays IDLE, no Inst_wen_o, Cpu_rst_n_o=0.
  - A following start with len=1 clears Err_o.
- Full depth: len=32.
  - Last write at addr 31 with no wrap; Load_ready_o drops after the 32nd beat.
  - Start pulses during LOAD are ignored.
- Reload and reset: from RUN, start with len=2.
  - Cpu_rst_n_o falls next cycle; reload completes.
  - Asserting Rst_n_i mid-LOAD on a second attempt forces all outputs to 0 asynchronously.
- LOADER_CHKSUM_EN: words 0x0003, 0xFFFF, Load_chk_i=0x0002 -> RUN. Repeat with Load_chk_i=0x0003 -> Err_o=1, core held in reset.
